// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit Hack core; the ALU sits outside.
// Define HALT_DETECT_EN to stop in a HALT state on the "@L; 0;JMP" self-loop idiom.
module hack_cpu_ctrl #(
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [14:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic        dmem_rd,
  output logic        dmem_we,
  output logic [14:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_o,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] pc,
  output logic        instr_done,
  output logic        halted
);

`ifdef HALT_DETECT_EN
  typedef enum logic [2:0] {StFetch, StMrd, StExec, StMwr, StHalt} state_e;
`else
  typedef enum logic [1:0] {StFetch, StMrd, StExec, StMwr} state_e;
`endif

  state_e      state_q, state_d;
  logic [14:0] pc_q, pc_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] mdr_q, mdr_d;
  logic [14:0] waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;

`ifdef HALT_DETECT_EN
  // PC of the last retired instruction, valid only if it was an A-instruction.
  logic [14:0] last_a_pc_q, last_a_pc_d;
  logic        last_a_vld_q, last_a_vld_d;
  logic        halt_pend_q, halt_pend_d;
  logic        halt_hit;
`endif

  logic        is_c;
  logic        dest_a, dest_d, dest_m;
  logic        jump_taken;
  logic [14:0] pc_inc;

  assign is_c   = ir_q[15];
  assign dest_a = ir_q[5];
  assign dest_d = ir_q[4];
  assign dest_m = ir_q[3];
  assign pc_inc = pc_q + 15'd1;

  assign jump_taken = is_c & ((ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) |
                              (ir_q[0] & ~alu_ng & ~alu_zr));

`ifdef HALT_DETECT_EN
  assign halt_hit = jump_taken & last_a_vld_q & (a_q[14:0] == last_a_pc_q);
`endif

  assign alu_x      = d_q;
  assign alu_y      = ir_q[12] ? mdr_q : a_q;
  assign alu_zx     = ir_q[11];
  assign alu_nx     = ir_q[10];
  assign alu_zy     = ir_q[9];
  assign alu_ny     = ir_q[8];
  assign alu_f      = ir_q[7];
  assign alu_no     = ir_q[6];
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign dmem_wdata = wdata_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    a_d        = a_q;
    d_d        = d_q;
    ir_d       = ir_q;
    mdr_d      = mdr_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    imem_req   = 1'b0;
    dmem_rd    = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = a_q[14:0];
    instr_done = 1'b0;
    halted     = 1'b0;
`ifdef HALT_DETECT_EN
    last_a_pc_d  = last_a_pc_q;
    last_a_vld_d = last_a_vld_q;
    halt_pend_d  = halt_pend_q;
`endif

    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = (imem_rdata[15] && imem_rdata[12]) ? StMrd : StExec;
        end
      end

      StMrd: begin
        dmem_rd = 1'b1;
        if (dmem_ready) begin
          mdr_d   = dmem_rdata;
          state_d = StExec;
        end
      end

      StExec: begin
        if (!is_c) begin
          a_d        = {1'b0, ir_q[14:0]};
          pc_d       = pc_inc;
          instr_done = 1'b1;
          state_d    = StFetch;
`ifdef HALT_DETECT_EN
          last_a_pc_d  = pc_q;
          last_a_vld_d = 1'b1;
`endif
        end else begin
          if (dest_d) d_d = alu_o;
          if (dest_a) a_d = alu_o;
          // Store address and jump target both come from A before this write.
          if (dest_m) begin
            waddr_d = a_q[14:0];
            wdata_d = alu_o;
          end
          pc_d = jump_taken ? a_q[14:0] : pc_inc;
`ifdef HALT_DETECT_EN
          last_a_vld_d = 1'b0;
`endif
          if (dest_m) begin
            state_d = StMwr;
`ifdef HALT_DETECT_EN
            halt_pend_d = halt_hit;
`endif
          end else begin
            instr_done = 1'b1;
`ifdef HALT_DETECT_EN
            state_d = halt_hit ? StHalt : StFetch;
`else
            state_d = StFetch;
`endif
          end
        end
      end

      StMwr: begin
        dmem_we   = 1'b1;
        dmem_addr = waddr_q;
        if (dmem_ready) begin
          instr_done = 1'b1;
`ifdef HALT_DETECT_EN
          state_d = halt_pend_q ? StHalt : StFetch;
`else
          state_d = StFetch;
`endif
        end
      end

`ifdef HALT_DETECT_EN
      StHalt: begin
        halted = 1'b1;
      end
`endif

      default: state_d = StFetch;
    endcase

    // Requests and pulses stay quiet while reset is held, whatever the state.
    if (reset) begin
      imem_req   = 1'b0;
      dmem_rd    = 1'b0;
      dmem_we    = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      a_q     <= '0;
      d_q     <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef HALT_DETECT_EN
      last_a_pc_q  <= '0;
      last_a_vld_q <= 1'b0;
      halt_pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef HALT_DETECT_EN
      last_a_pc_q  <= last_a_pc_d;
      last_a_vld_q <= last_a_vld_d;
      halt_pend_q  <= halt_pend_d;
`endif
    end
  end

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
- Multi-cycle control/datapath sequencer for the 16-bit Hack-style core.
- Fetches instructions, decodes A/C instructions and drives the ALU control inputs (zx, nx, zy, ny, f, no) and operands.
- Consumes the ALU result and its zr/ng flags, updates the A, D and PC registers, and evaluates jumps.
- Sits between instruction/data memory (req/ready handshakes) and the combinational ALU, which is instantiated beside it at top level.

Parameters:
- RESET_PC, 15'h0000, PC value loaded on reset.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  15  fetch address, equal to PC.
- imem_ready  in  1  fetch complete; imem_rdata is valid.
- imem_rdata  in  16  instruction word.
- dmem_rd  out  1  data read request.
- dmem_we  out  1  data write request.
- dmem_addr  out  15  data address.
- dmem_wdata  out  16  write data.
- dmem_rdata  in  16  read data, valid when dmem_ready is high.
- dmem_ready  in  1  data transaction complete.
- alu_x  out  16  D register.
- alu_y  out  16  A register, or MDR when IR[12] = 1.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  driven from IR[11:6].
- alu_o  in  16  ALU result.
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.
- pc  out  15  current PC.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- halted  out  1  see Optional Feature.

Behaviour:
- Reset (synchronous, active-high):
  - PC = RESET_PC; A, D, IR and MDR = 0; state = FETCH.
  - All requests, instr_done and halted are low during the reset cycle.
  - A reset asserted mid-transaction drops every request on the next edge. Memory must tolerate abandoned requests.
- Handshake rules:
  - A request is held high, with address and data stable, until ready is sampled high on a rising edge.
  - Zero-wait operation is allowed: ready may be high in the first request cycle, and the transaction completes that edge.
  - Ready is ignored when no request is active.
  - At most one of imem_req, dmem_rd and dmem_we is high in any cycle.
- Instruction format:
  - IR[15] = 0 is an A-instruction.
  - Otherwise it is a C-instruction: a = IR[12], comp = IR[11:6], dest = IR[5:3] (A, D, M), jump = IR[2:0] (lt, eq, gt).
- State FETCH:
  - imem_req = 1.
  - On imem_ready: IR <= imem_rdata.
  - Next state is MRD if the fetched word is a C-instruction with a = 1; otherwise EXEC.
- State MRD:
  - dmem_rd = 1, dmem_addr = A[14:0].
  - On dmem_ready: MDR <= dmem_rdata; next state EXEC.
- State EXEC (exactly one cycle):
  - A-instruction: A <= {1'b0, IR[14:0]}; PC <= PC + 1; next state FETCH.
  - C-instruction register writes:
    - dest.D: D <= alu_o.
    - dest.A: A <= alu_o.
    - dest.M: latch WADDR <= A[14:0] (old A) and WDATA <= alu_o.
  - Jump evaluation:
    - Jump is taken when (j_lt & ng) | (j_eq & zr) | (j_gt & ~ng & ~zr).
    - Taken: PC <= old A[14:0]. Not taken: PC <= PC + 1.
    - PC is 15 bits and wraps 0x7FFF -> 0x0000.
  - Next state is MWR if dest.M, else FETCH.
  - instr_done pulses in EXEC unless going to MWR.
  - Simultaneous dest.A with dest.M or a jump: the memory address and jump target use the pre-update A.
- State MWR:
  - dmem_we = 1, dmem_addr = WADDR, dmem_wdata = WDATA.
  - On dmem_ready: instr_done pulses; next state FETCH.
- ALU control outputs are driven from IR in all states; they are only meaningful in EXEC.
- Latency: an A-instruction takes 2 cycles; a C-instruction takes 2 to 4 cycles, plus any memory wait states.

Optional Feature:
- Macro: HALT_DETECT_EN.
- With the macro defined:
  - A taken jump whose target equals the PC of the immediately preceding A-instruction (the "@L; 0;JMP" self-loop) moves the FSM to state HALT.
  - In HALT, halted = 1, no requests are issued, and the state is held until reset.
- Without the macro: halted is tied to 0, the HALT state does not exist, and the loop executes forever.

Test Plan:
- Reset, then program 0x1234, zero-wait memory -> A = 0x1234, PC 0 -> 1, one instr_done pulse, dmem idle.
- Program 0x0005, 0xEC10 (D=A), 0xE308 (M=D) -> D = 5; dmem_we with addr 5, wdata 0x0005; PC = 3.
- Program 0x0005, 0xFC10 (D=M), dmem_ready delayed 3 cycles, rdata 0x00AA -> dmem_rd held high 3 cycles with addr 5; D = 0x00AA.
- Program 0x000A, 0xEE90 (D=-1), 0xE304 (D;JLT) -> PC = 10.
- Jump not taken: repeat the previous scenario with D = 0 -> PC = 3.
- Program A = 7, then 0xFDE8 (AM=M+1) with M[7] = 0x0009 -> write addr 7, data 0x000A; A = 0x000A.
- Reset asserted while dmem_rd is waiting -> dmem_rd = 0 the next cycle, PC = 0, fetch restarts.
- HALT_DETECT_EN: program at PC 2 = 0x0002, PC 3 = 0xEA87 -> halted = 1 and no further imem_req.
